stack_calc_core: RTL and testbench
==================================

# stack_calc_core

Parametrised stack calculator engine. It holds a LIFO operand stack in internal synchronous RAM and executes push, pop, two-operand arithmetic, clear and memory-browse commands over a valid/ready command port. It exports a registered view of one stack location for the board-level display and LED drivers. It replaces the button-driven fixed-width calculator datapath at the top level, with configurable data width and depth, overflow/underflow detection and a proper handshake.

## Interface
- `DATA_W`, 8: operand and RAM word width in bits (≥2).
- `DEPTH`, 128: stack entries, power of two ≥4. Localparam `ADDR_W = $clog2(DEPTH)`.
- `clk` in 1: sole clock. All state is updated on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the core accepts a command. High only in IDLE.
- `cmd_op` in 4: opcode. 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 CLEAR, 5 TOP, 6 BR_DEC, 7 BR_INC, 8 MUL.
- `cmd_data` in DATA_W: PUSH operand, sampled at acceptance.
- `disp_addr` out ADDR_W: address currently viewed.
- `disp_data` out DATA_W: registered copy of RAM[`disp_addr`].
- `used` out ADDR_W+1: number of entries on the stack.
- `empty` out 1: `used` == 0.
- `full` out 1: `used` == DEPTH.
- `err` out 1: sticky error flag.

## Operation
- Storage: entries occupy RAM[0..used-1]. The top of stack is RAM[used-1]. RAM has a synchronous write and a 1-cycle synchronous read. RAM is never reset or cleared.
- Acceptance: a command is accepted on an edge where `cmd_valid` and `cmd_ready` are both high. The opcode and data are latched at that edge.
- FSM states: IDLE, RD_A, RD_B, EXEC, WR, UPD, REFR, LOAD.
- PUSH: IDLE→WR. WR writes RAM[used]=data, increments `used`, and sets `disp_addr`=old `used`. Then →REFR.
- POP: IDLE→UPD. UPD decrements `used` and sets `disp_addr`=new `used`-1 (0 if the stack is now empty). Then →REFR.
- ADD/SUB/MUL: IDLE→RD_A (read the top, A)→RD_B (capture A, read B=RAM[used-2])→EXEC (capture B, compute R)→WR. WR writes RAM[used-2]=R, decrements `used`, and points `disp_addr` at the new top. Then →REFR.
- Arithmetic results, modulo 2^DATA_W:
  - ADD: R=B+A.
  - SUB: R=B−A.
  - MUL: low DATA_W bits of B×A.
- CLEAR: IDLE→UPD. Sets `used`=0, `err`=0, `disp_addr`=0. Then →REFR.
- TOP: IDLE→UPD. Sets `disp_addr`=`used`-1 (0 if empty). Then →REFR.
- BR_DEC/BR_INC: IDLE→UPD. Moves `disp_addr` by ∓1, wrapping modulo DEPTH. Browsing may view addresses ≥ `used`; those show stale RAM contents.
- REFR issues a read at `disp_addr`. LOAD captures the result into `disp_data` and returns to IDLE.
- When `used`==0 after any command other than browse, LOAD loads 0 rather than RAM.
- Errors set `err`, leave `used`, RAM and `disp_*` unchanged, and the FSM stays in IDLE. An error is raised by:
  - PUSH when full.
  - POP when empty.
  - ADD/SUB/MUL when `used`<2.
  - Opcodes 9–15.
  - MUL when the macro is absent.
- `err` clears only on CLEAR or reset.

## Timing
- Reset values: IDLE, `cmd_ready`=1, `used`=0, `empty`=1, `full`=0, `err`=0, `disp_addr`=0, `disp_data`=0.
- Busy cycles between acceptance and `cmd_ready` reasserting:
  - PUSH: 3.
  - POP, CLEAR, TOP, BR_*: 3.
  - ADD/SUB/MUL: 6.
  - Error: 0. `err` is high in the cycle after acceptance and `cmd_ready` never drops.
- `used`, `empty` and `full` update at the WR/UPD edge. `disp_data` is valid when `cmd_ready` returns.
- `cmd_valid` held high while busy is ignored. There is no queueing.
- Reset mid-operation aborts immediately. No RAM write occurs unless the WR edge has already passed.

## Configuration
- `STACK_CALC_MUL_EN` defined: opcode 8 performs MUL with the same 6-cycle timing as ADD.
- `STACK_CALC_MUL_EN` undefined: no multiplier is built, and opcode 8 is illegal and sets `err`.

## Test plan
- DATA_W=8. PUSH 0x05, PUSH 0x03, SUB → `used`=1, `disp_data`=0x02, `cmd_ready` back 6 cycles after SUB acceptance.
- PUSH 0xF0, PUSH 0x20, ADD → `disp_data`=0x10 (wrap). Then PUSH 0x07, PUSH 0x06, MUL → 0x2A with the macro; without the macro → `err`=1, `used`=3, `disp_data`=0x06.
- DEPTH=4. Four PUSHes then PUSH 0x99 → `err`=1, `full`=1, `used`=4, top unchanged. Then CLEAR → `err`=0, `empty`=1, `disp_data`=0.
- Underflow:
  - From empty, POP → `err`=1, `used`=0.
  - From empty, PUSH 0x01 then ADD → `err`=1, `used`=1, `disp_data`=0x01.
- DEPTH=4. PUSH 0x11, 0x22, 0x33 → `disp_addr`=2. BR_DEC → addr 1, data 0x22. BR_DEC ×2 → addr 3 (wrap). TOP → addr 2, data 0x33.
- PUSH 0x0A, PUSH 0x0B, ADD, then pull `rst_n` low during EXEC → all outputs at reset values. After re-pushing 0x01 and TOP, `disp_data`=0x01.

Source files
------------

// File: rtl/stack_calc_core.sv
// Stack calculator engine: LIFO operand stack in synchronous RAM with a valid/ready command port.
// Define STACK_CALC_MUL_EN to build the multiplier; otherwise opcode 8 is illegal.
module stack_calc_core #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 128,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W:0]   used,
    output logic              empty,
    output logic              full,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR, UPD, REFR, LOAD} state_t;

    localparam logic [3:0] OP_PUSH   = 4'd0;
    localparam logic [3:0] OP_POP    = 4'd1;
    localparam logic [3:0] OP_ADD    = 4'd2;
    localparam logic [3:0] OP_SUB    = 4'd3;
    localparam logic [3:0] OP_CLEAR  = 4'd4;
    localparam logic [3:0] OP_TOP    = 4'd5;
    localparam logic [3:0] OP_BR_DEC = 4'd6;
    localparam logic [3:0] OP_BR_INC = 4'd7;
    localparam logic [3:0] OP_MUL    = 4'd8;

`ifdef STACK_CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    state_t              state_reg;
    logic [3:0]          op_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   a_reg;
    logic [DATA_W-1:0]   result_reg;
    logic [ADDR_W:0]     used_reg;
    logic                err_reg;
    logic                ready_reg;
    logic [ADDR_W-1:0]   disp_addr_reg;
    logic [DATA_W-1:0]   disp_data_reg;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data_reg;

    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [ADDR_W-1:0]   top_addr;
    logic [ADDR_W-1:0]   second_addr;
    logic                is_full;
    logic                is_empty;
    logic                below_two;
    logic                cmd_err;
    state_t              start_state;
    logic [DATA_W-1:0]   alu_result;

    // Low address bits wrap correctly even when used == DEPTH.
    assign top_addr    = used_reg[ADDR_W-1:0] - ADDR_W'(1);
    assign second_addr = used_reg[ADDR_W-1:0] - ADDR_W'(2);
    assign is_full     = (used_reg == (ADDR_W+1)'(DEPTH));
    assign is_empty    = (used_reg == '0);
    assign below_two   = (used_reg < (ADDR_W+1)'(2));

    always_comb begin
        cmd_err     = 1'b0;
        start_state = UPD;
        case (cmd_op)
            OP_PUSH: begin
                cmd_err     = is_full;
                start_state = WR;
            end
            OP_POP: cmd_err = is_empty;
            OP_ADD, OP_SUB: begin
                cmd_err     = below_two;
                start_state = RD_A;
            end
            OP_MUL: begin
                cmd_err     = !MUL_EN || below_two;
                start_state = RD_A;
            end
            OP_CLEAR, OP_TOP, OP_BR_DEC, OP_BR_INC: cmd_err = 1'b0;
            default: cmd_err = 1'b1;
        endcase
    end

    // B arrives from RAM during EXEC; A was captured one cycle earlier.
    always_comb begin
        alu_result = rd_data_reg + a_reg;
        case (op_reg)
            OP_SUB: alu_result = rd_data_reg - a_reg;
`ifdef STACK_CALC_MUL_EN
            OP_MUL: alu_result = rd_data_reg * a_reg;
`endif
            default: alu_result = rd_data_reg + a_reg;
        endcase
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = disp_addr_reg;
        wr_en   = 1'b0;
        wr_addr = second_addr;
        wr_data = result_reg;
        case (state_reg)
            RD_A: begin
                rd_en   = 1'b1;
                rd_addr = top_addr;
            end
            RD_B: begin
                rd_en   = 1'b1;
                rd_addr = second_addr;
            end
            REFR: rd_en = 1'b1;
            WR: begin
                wr_en = 1'b1;
                if (op_reg == OP_PUSH) begin
                    wr_addr = used_reg[ADDR_W-1:0];
                    wr_data = data_reg;
                end
            end
            default: rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_PUSH;
            data_reg      <= '0;
            a_reg         <= '0;
            result_reg    <= '0;
            used_reg      <= '0;
            err_reg       <= 1'b0;
            ready_reg     <= 1'b1;
            disp_addr_reg <= '0;
            disp_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg   <= cmd_op;
                        data_reg <= cmd_data;
                        if (cmd_err) begin
                            err_reg <= 1'b1;
                        end else begin
                            ready_reg <= 1'b0;
                            state_reg <= start_state;
                        end
                    end
                end
                RD_A: state_reg <= RD_B;
                RD_B: begin
                    a_reg     <= rd_data_reg;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    result_reg <= alu_result;
                    state_reg  <= WR;
                end
                WR: begin
                    if (op_reg == OP_PUSH) begin
                        used_reg      <= used_reg + (ADDR_W+1)'(1);
                        disp_addr_reg <= used_reg[ADDR_W-1:0];
                    end else begin
                        used_reg      <= used_reg - (ADDR_W+1)'(1);
                        disp_addr_reg <= second_addr;
                    end
                    state_reg <= REFR;
                end
                UPD: begin
                    case (op_reg)
                        OP_POP: begin
                            used_reg      <= used_reg - (ADDR_W+1)'(1);
                            disp_addr_reg <= (used_reg == (ADDR_W+1)'(1)) ? '0 : second_addr;
                        end
                        OP_CLEAR: begin
                            used_reg      <= '0;
                            err_reg       <= 1'b0;
                            disp_addr_reg <= '0;
                        end
                        OP_TOP:    disp_addr_reg <= is_empty ? '0 : top_addr;
                        OP_BR_DEC: disp_addr_reg <= disp_addr_reg - ADDR_W'(1);
                        OP_BR_INC: disp_addr_reg <= disp_addr_reg + ADDR_W'(1);
                        default:   disp_addr_reg <= disp_addr_reg;
                    endcase
                    state_reg <= REFR;
                end
                REFR: state_reg <= LOAD;
                LOAD: begin
                    // Browsing shows raw RAM even past the top; everything else blanks an empty stack.
                    if (is_empty && op_reg != OP_BR_DEC && op_reg != OP_BR_INC)
                        disp_data_reg <= '0;
                    else
                        disp_data_reg <= rd_data_reg;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_reg;
    assign disp_addr = disp_addr_reg;
    assign disp_data = disp_data_reg;
    assign used      = used_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign err       = err_reg;

endmodule

// File: tb/tb_stack_calc_core.sv
// Self-checking bench for stack_calc_core (DEPTH=4, DATA_W=8) with a behavioural stack model.
// Honours STACK_CALC_MUL_EN the same way as the design.
module tb_stack_calc_core;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

`ifdef STACK_CALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic [ADDR_W:0]   used;
    logic              empty;
    logic              full;
    logic              err;

    stack_calc_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .used      (used),
        .empty     (empty),
        .full      (full),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the stack is an array plus a count; each command is applied atomically.
    int         m_used = 0;
    logic [7:0] m_mem [DEPTH];
    logic       m_err  = 1'b0;
    int         m_addr = 0;
    logic [7:0] m_data = 8'h00;

    task automatic model_apply(input logic [3:0] op, input logic [7:0] d, output int busy);
        logic [7:0] a, b, r;
        busy = 3;
        case (op)
            0: if (m_used == DEPTH) begin m_err = 1'b1; busy = 0; end
               else begin m_mem[m_used] = d; m_addr = m_used; m_used++; m_data = d; end
            1: if (m_used == 0) begin m_err = 1'b1; busy = 0; end
               else begin
                   m_used--;
                   m_addr = (m_used == 0) ? 0 : m_used - 1;
                   m_data = (m_used == 0) ? 8'h00 : m_mem[m_addr];
               end
            2, 3, 8: if ((op == 8 && !MUL_EN) || m_used < 2) begin m_err = 1'b1; busy = 0; end
               else begin
                   a = m_mem[m_used-1];
                   b = m_mem[m_used-2];
                   if (op == 2)      r = b + a;
                   else if (op == 3) r = b - a;
                   else              r = 8'(b * a);
                   m_mem[m_used-2] = r;
                   m_used--;
                   m_addr = m_used - 1;
                   m_data = r;
                   busy = 6;
               end
            4: begin m_used = 0; m_err = 1'b0; m_addr = 0; m_data = 8'h00; end
            5: begin
                   m_addr = (m_used == 0) ? 0 : m_used - 1;
                   m_data = (m_used == 0) ? 8'h00 : m_mem[m_addr];
               end
            6: begin m_addr = (m_addr + DEPTH - 1) % DEPTH; m_data = m_mem[m_addr]; end
            7: begin m_addr = (m_addr + 1) % DEPTH; m_data = m_mem[m_addr]; end
            default: begin m_err = 1'b1; busy = 0; end
        endcase
    endtask

    // Drives one command (valid held while busy), updates the model, reports measured busy cycles.
    task automatic do_cmd(input logic [3:0] op, input logic [7:0] d,
                          output int busy, output logic err_first, output int exp_busy);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        model_apply(op, d, exp_busy);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        @(negedge clk);
        err_first = err;
        busy = 0;
        while (!cmd_ready && busy < 40) begin busy++; @(negedge clk); end
        if (!cmd_ready) busy = -1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if (used !== 3'd0) $display("FAIL reset_used: got %0d want 0", used); else n_pass++;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (disp_addr !== 2'd0 || disp_data !== 8'h00) $display("FAIL reset_disp: got %0d/%h want 0/00", disp_addr, disp_data); else n_pass++;
    endtask

    task automatic test_sub;
        int bz, eb;
        logic e1;
        do_cmd(0, 8'h05, bz, e1, eb);
        do_cmd(0, 8'h03, bz, e1, eb);
        do_cmd(3, 8'h00, bz, e1, eb);
        n_checks++; if (bz !== 6) $display("FAIL sub_busy: got %0d want 6", bz); else n_pass++;
        n_checks++; if (used !== 3'd1) $display("FAIL sub_used: got %0d want 1", used); else n_pass++;
        n_checks++; if (disp_data !== 8'h02) $display("FAIL sub_data: got %h want 02", disp_data); else n_pass++;
    endtask

    task automatic test_add_mul;
        int bz, eb;
        logic e1;
        do_cmd(4, 8'h00, bz, e1, eb);
        do_cmd(0, 8'hF0, bz, e1, eb);
        do_cmd(0, 8'h20, bz, e1, eb);
        do_cmd(2, 8'h00, bz, e1, eb);
        n_checks++; if (disp_data !== 8'h10) $display("FAIL add_wrap: got %h want 10", disp_data); else n_pass++;
        n_checks++; if (bz !== 6) $display("FAIL add_busy: got %0d want 6", bz); else n_pass++;
        do_cmd(0, 8'h07, bz, e1, eb);
        do_cmd(0, 8'h06, bz, e1, eb);
        do_cmd(8, 8'h00, bz, e1, eb);
`ifdef STACK_CALC_MUL_EN
        n_checks++; if (disp_data !== 8'h2A || used !== 3'd2 || err !== 1'b0) $display("FAIL mul: got data=%h used=%0d err=%b want 2a/2/0", disp_data, used, err); else n_pass++;
        n_checks++; if (bz !== 6) $display("FAIL mul_busy: got %0d want 6", bz); else n_pass++;
`else
        n_checks++; if (err !== 1'b1 || used !== 3'd3 || disp_data !== 8'h06) $display("FAIL mul_illegal: got err=%b used=%0d data=%h want 1/3/06", err, used, disp_data); else n_pass++;
        n_checks++; if (bz !== 0) $display("FAIL mul_busy: got %0d want 0", bz); else n_pass++;
`endif
    endtask

    task automatic test_overflow;
        int bz, eb;
        logic e1;
        do_cmd(4, 8'h00, bz, e1, eb);
        for (int i = 0; i < 4; i++) do_cmd(0, 8'hA1 + 8'(i), bz, e1, eb);
        n_checks++; if (full !== 1'b1 || used !== 3'd4) $display("FAIL fill: got full=%b used=%0d want 1/4", full, used); else n_pass++;
        do_cmd(0, 8'h99, bz, e1, eb);
        n_checks++; if (err !== 1'b1 || full !== 1'b1 || used !== 3'd4) $display("FAIL overflow: got err=%b full=%b used=%0d want 1/1/4", err, full, used); else n_pass++;
        n_checks++; if (disp_data !== 8'hA4 || disp_addr !== 2'd3 || bz !== 0) $display("FAIL overflow_top: got %h@%0d busy %0d want a4@3 busy 0", disp_data, disp_addr, bz); else n_pass++;
        do_cmd(4, 8'h00, bz, e1, eb);
        n_checks++; if (err !== 1'b0 || empty !== 1'b1 || disp_data !== 8'h00) $display("FAIL clear: got err=%b empty=%b data=%h want 0/1/00", err, empty, disp_data); else n_pass++;
    endtask

    task automatic test_underflow;
        int bz, eb;
        logic e1;
        do_cmd(1, 8'h00, bz, e1, eb);
        n_checks++; if (e1 !== 1'b1 || bz !== 0) $display("FAIL pop_empty_timing: got err1=%b busy=%0d want 1/0", e1, bz); else n_pass++;
        n_checks++; if (err !== 1'b1 || used !== 3'd0) $display("FAIL pop_empty: got err=%b used=%0d want 1/0", err, used); else n_pass++;
        do_cmd(4, 8'h00, bz, e1, eb);
        do_cmd(0, 8'h01, bz, e1, eb);
        do_cmd(2, 8'h00, bz, e1, eb);
        n_checks++; if (err !== 1'b1 || used !== 3'd1 || disp_data !== 8'h01) $display("FAIL add_one: got err=%b used=%0d data=%h want 1/1/01", err, used, disp_data); else n_pass++;
    endtask

    task automatic test_browse;
        int bz, eb;
        logic e1;
        do_cmd(4, 8'h00, bz, e1, eb);
        do_cmd(0, 8'h11, bz, e1, eb);
        do_cmd(0, 8'h22, bz, e1, eb);
        do_cmd(0, 8'h33, bz, e1, eb);
        n_checks++; if (disp_addr !== 2'd2) $display("FAIL push_addr: got %0d want 2", disp_addr); else n_pass++;
        do_cmd(6, 8'h00, bz, e1, eb);
        n_checks++; if (disp_addr !== 2'd1 || disp_data !== 8'h22 || bz !== 3) $display("FAIL br_dec: got %h@%0d busy %0d want 22@1 busy 3", disp_data, disp_addr, bz); else n_pass++;
        do_cmd(6, 8'h00, bz, e1, eb);
        do_cmd(6, 8'h00, bz, e1, eb);
        n_checks++; if (disp_addr !== 2'd3 || disp_data !== 8'hA4) $display("FAIL br_wrap: got %h@%0d want a4@3", disp_data, disp_addr); else n_pass++;
        do_cmd(5, 8'h00, bz, e1, eb);
        n_checks++; if (disp_addr !== 2'd2 || disp_data !== 8'h33) $display("FAIL top: got %h@%0d want 33@2", disp_data, disp_addr); else n_pass++;
    endtask

    task automatic test_reset_midop;
        int bz, eb;
        logic e1;
        do_cmd(4, 8'h00, bz, e1, eb);
        do_cmd(0, 8'h0A, bz, e1, eb);
        do_cmd(0, 8'h0B, bz, e1, eb);
        do_cmd(12, 8'h00, bz, e1, eb);
        cmd_valid = 1'b1;
        cmd_op    = 4'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1 || used !== 3'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL midop_state: got ready=%b used=%0d empty=%b full=%b want 1/0/1/0", cmd_ready, used, empty, full); else n_pass++;
        n_checks++; if (err !== 1'b0 || disp_addr !== 2'd0 || disp_data !== 8'h00) $display("FAIL midop_disp: got err=%b %h@%0d want 0 00@0", err, disp_data, disp_addr); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_used = 0; m_err = 1'b0; m_addr = 0; m_data = 8'h00;
        do_cmd(0, 8'h01, bz, e1, eb);
        do_cmd(5, 8'h00, bz, e1, eb);
        n_checks++; if (disp_data !== 8'h01 || used !== 3'd1) $display("FAIL midop_after: got data=%h used=%0d want 01/1", disp_data, used); else n_pass++;
    endtask

    task automatic test_random;
        int bz, eb, r;
        logic e1;
        logic [3:0] op;
        logic [7:0] d;
        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 19));
            op = (r < 18) ? 4'(r % 9) : 4'(9 + $urandom_range(0, 6));
            d  = 8'($urandom);
            do_cmd(op, d, bz, e1, eb);
            n_checks++; if (bz !== eb) $display("FAIL rnd_busy #%0d op %0d: got %0d want %0d", i, op, bz, eb); else n_pass++;
            n_checks++; if (used !== 3'(m_used)) $display("FAIL rnd_used #%0d op %0d: got %0d want %0d", i, op, used, m_used); else n_pass++;
            n_checks++; if (empty !== (m_used == 0) || full !== (m_used == DEPTH)) $display("FAIL rnd_flags #%0d: got empty=%b full=%b used_model=%0d", i, empty, full, m_used); else n_pass++;
            n_checks++; if (err !== m_err) $display("FAIL rnd_err #%0d op %0d: got %b want %b", i, op, err, m_err); else n_pass++;
            n_checks++; if (disp_addr !== 2'(m_addr)) $display("FAIL rnd_addr #%0d op %0d: got %0d want %0d", i, op, disp_addr, m_addr); else n_pass++;
            n_checks++; if (disp_data !== m_data) $display("FAIL rnd_data #%0d op %0d: got %h want %h", i, op, disp_data, m_data); else n_pass++;
            $display("cmd %0d op=%0d data=%h -> used=%0d err=%b disp=%h@%0d busy=%0d", i, op, d, used, err, disp_data, disp_addr, bz);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_sub();
        test_add_mul();
        test_overflow();
        test_underflow();
        test_browse();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
